// File: rtl/switch_poll_pkg.sv
// switch_poll_pkg: shared types and constants for the switch poll controller.
// Holds the FSM encoding, the PIO data address and the event record layout.
package switch_poll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EVAL
    } poll_state_e;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         SW_W_DEF      = 10;

    typedef struct packed {
        logic [SW_W_DEF-1:0] changed_mask;
        logic [SW_W_DEF-1:0] value;
    } sw_evt_t;

endpackage

// File: rtl/switch_evt_fifo.sv
// switch_evt_fifo: small synchronous FIFO with a registered head entry.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module switch_evt_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/switch_poll_ctrl.sv
// switch_poll_ctrl: periodic Avalon-MM poller, debouncer and event queue for the switch PIO.
// SWITCH_POLL_TIMEOUT_EN adds a 15-cycle read watchdog and the timeout_err output.
module switch_poll_ctrl
    import switch_poll_pkg::*;
#(
    parameter int POLL_DIV   = 50000,
    parameter int DEBOUNCE_N = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SW_W       = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic [31:0]       avm_readdata,
    output logic [SW_W-1:0]   stable_sw,
    output logic              evt_valid,
    output logic [2*SW_W-1:0] evt_data,
    input  logic              evt_ready,
    output logic              irq,
    output logic              overflow,
    input  logic              clr_ovf
`ifdef SWITCH_POLL_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);
    localparam int            TW        = $clog2(POLL_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(POLL_DIV - 1);
    localparam logic [7:0]    DB_N      = 8'(DEBOUNCE_N);

    poll_state_e      state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             tick;
    logic             pend_q, pend_d;
    logic [SW_W-1:0]  sample_q, sample_d;
    logic [SW_W-1:0]  last_q, last_d;
    logic [SW_W-1:0]  stable_q, stable_d;
    logic [7:0]       dcnt_q, dcnt_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic [2*SW_W-1:0] push_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             unused_rd_bits;
`ifdef SWITCH_POLL_TIMEOUT_EN
    logic [3:0]       wd_q, wd_d;
    logic             tmo_q, tmo_d;
    logic             tmo_set;
`endif

    assign tick   = enable && (tick_q == TICK_LAST);
    assign tick_d = (!enable || tick) ? '0 : tick_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        sample_d = sample_q;
        last_d   = last_q;
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        push     = 1'b0;
`ifdef SWITCH_POLL_TIMEOUT_EN
        wd_d     = wd_q;
        tmo_set  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (enable && (tick || pend_q)) begin
                    state_d = ST_REQ;
                    pend_d  = 1'b0;
                end
            end
            ST_REQ: begin
`ifdef SWITCH_POLL_TIMEOUT_EN
                wd_d = '0;
`endif
                if (!avm_waitrequest) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (avm_readdatavalid) begin
                    sample_d = avm_readdata[SW_W-1:0];
                    state_d  = ST_EVAL;
                end
`ifdef SWITCH_POLL_TIMEOUT_EN
                else if (wd_q == 4'd14) begin
                    state_d = ST_IDLE;
                    tmo_set = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_EVAL: begin
                if (sample_q != last_q) begin
                    last_d = sample_q;
                    dcnt_d = 8'd1;
                end else if (dcnt_q != DB_N) begin
                    dcnt_d = dcnt_q + 1'b1;
                end
                if (dcnt_d == DB_N && sample_q != stable_q) begin
                    stable_d = sample_q;
                    push     = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Only one tick can be remembered while a read is in flight.
        if (tick && state_q != ST_IDLE) pend_d = 1'b1;
        if (!enable) pend_d = 1'b0;
    end

    assign push_data = {sample_q ^ stable_q, sample_q};
    assign ovf_d     = (push && fifo_full && !evt_ready) || (ovf_q && !clr_ovf);
`ifdef SWITCH_POLL_TIMEOUT_EN
    assign tmo_d       = tmo_set || (tmo_q && !clr_ovf);
    assign timeout_err = tmo_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            pend_q   <= 1'b0;
            sample_q <= '0;
            last_q   <= '0;
            stable_q <= '0;
            dcnt_q   <= '0;
            ovf_q    <= 1'b0;
`ifdef SWITCH_POLL_TIMEOUT_EN
            wd_q     <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            sample_q <= sample_d;
            last_q   <= last_d;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            ovf_q    <= ovf_d;
`ifdef SWITCH_POLL_TIMEOUT_EN
            wd_q     <= wd_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    switch_evt_fifo #(
        .W     (2 * SW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (evt_ready),
        .data_o  (evt_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign avm_address    = PIO_DATA_ADDR;
    assign avm_read       = (state_q == ST_REQ);
    assign stable_sw      = stable_q;
    assign evt_valid      = !fifo_empty;
    assign irq            = !fifo_empty;
    assign overflow       = ovf_q;
    assign unused_rd_bits = ^avm_readdata[31:SW_W];

endmodule
